// File: rtl/fft_pkg.sv
// Shared constants and helpers for the 16-point FFT datapath.
// Samples are 1 sign + 4 exponent + 4 significand bits, packed four lanes per vector bus.
package fft_pkg;

    localparam int unsigned EXP_WIDTH    = 4;
    localparam int unsigned SIG_WIDTH    = 4;
    localparam int unsigned FORMAT_WIDTH = 1 + EXP_WIDTH + SIG_WIDTH;
    localparam int unsigned VEC          = 4;

    // Lane j of a packed vector bus; lane 0 sits in the least significant bits.
    function automatic logic [FORMAT_WIDTH-1:0] lane(input logic [FORMAT_WIDTH*VEC-1:0] bus,
                                                     input int unsigned j);
        return bus[FORMAT_WIDTH*j +: FORMAT_WIDTH];
    endfunction

endpackage

// File: rtl/fft_transpose_bank.sv
// One 4x4 bank of the corner-turn buffer: rows are written whole, columns are read whole.
// Contents are deliberately left unreset; the full flags in the top qualify them.
module transpose_bank
    import fft_pkg::*;
(
    input  logic                        clk,
    input  logic                        we,
    input  logic [1:0]                  row,
    input  logic [FORMAT_WIDTH*VEC-1:0] wr_real,
    input  logic [FORMAT_WIDTH*VEC-1:0] wr_imag,
    input  logic [1:0]                  col,
    output logic [FORMAT_WIDTH*VEC-1:0] rd_real,
    output logic [FORMAT_WIDTH*VEC-1:0] rd_imag
);

    logic [FORMAT_WIDTH-1:0] mem_re [VEC][VEC];
    logic [FORMAT_WIDTH-1:0] mem_im [VEC][VEC];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int unsigned j = 0; j < VEC; j++) begin
                mem_re[row][j] <= lane(wr_real, j);
                mem_im[row][j] <= lane(wr_imag, j);
            end
        end
    end

    // Output lane r carries element (row r, column col).
    always_comb begin
        rd_real = '0;
        rd_imag = '0;
        for (int unsigned r = 0; r < VEC; r++) begin
            rd_real[FORMAT_WIDTH*r +: FORMAT_WIDTH] = mem_re[r][col];
            rd_imag[FORMAT_WIDTH*r +: FORMAT_WIDTH] = mem_im[r][col];
        end
    end

endmodule

// File: rtl/fft_transpose_buffer.sv
// Ping-pong 4x4 corner-turn buffer: one bank fills with rows while the other drains as columns.
// The top owns bank pointers, full flags, row/column counters, handshakes and overflow.
module fft_transpose_buffer
    import fft_pkg::*;
#(
    parameter int unsigned formatWidth = FORMAT_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [formatWidth*VEC-1:0] in_real,
    input  logic [formatWidth*VEC-1:0] in_imag,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [formatWidth*VEC-1:0] out_real,
    output logic [formatWidth*VEC-1:0] out_imag,
    output logic [1:0]                 col_idx,
    output logic                       frame_done,
    output logic                       overflow
);

    logic       wr_bank_q, wr_bank_d;
    logic       rd_bank_q, rd_bank_d;
    logic [1:0] wr_row_q, wr_row_d;
    logic [1:0] col_q, col_d;
    logic [1:0] full_q, full_d;
    logic       overflow_q, overflow_d;

    logic wr_en;
    logic rd_en;

    logic [formatWidth*VEC-1:0] bank_real [2];
    logic [formatWidth*VEC-1:0] bank_imag [2];

    assign in_ready   = !full_q[wr_bank_q];
    assign out_valid  = full_q[rd_bank_q];
    assign wr_en      = in_valid && in_ready;
    assign rd_en      = out_valid && out_ready;
    assign col_idx    = col_q;
    assign frame_done = rd_en && (col_q == 2'd3);
    assign overflow   = overflow_q;
    assign out_real   = bank_real[rd_bank_q];
    assign out_imag   = bank_imag[rd_bank_q];

    for (genvar b = 0; b < 2; b++) begin : g_bank
        transpose_bank u_bank (
            .clk     (clk),
            .we      (wr_en && (wr_bank_q == 1'(b))),
            .row     (wr_row_q),
            .wr_real (in_real),
            .wr_imag (in_imag),
            .col     (col_q),
            .rd_real (bank_real[b]),
            .rd_imag (bank_imag[b])
        );
    end

    // Write side only sets its bank's flag and read side only clears its own, so they never collide.
    always_comb begin
        wr_bank_d  = wr_bank_q;
        rd_bank_d  = rd_bank_q;
        wr_row_d   = wr_row_q;
        col_d      = col_q;
        full_d     = full_q;
        overflow_d = overflow_q || (in_valid && !in_ready);
        if (wr_en) begin
            wr_row_d = wr_row_q + 2'd1;
            if (wr_row_q == 2'd3) begin
                full_d[wr_bank_q] = 1'b1;
                wr_bank_d         = !wr_bank_q;
            end
        end
        if (rd_en) begin
            col_d = col_q + 2'd1;
            if (col_q == 2'd3) begin
                full_d[rd_bank_q] = 1'b0;
                rd_bank_d         = !rd_bank_q;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_bank_q  <= 1'b0;
            rd_bank_q  <= 1'b0;
            wr_row_q   <= 2'd0;
            col_q      <= 2'd0;
            full_q     <= 2'b00;
            overflow_q <= 1'b0;
        end else begin
            wr_bank_q  <= wr_bank_d;
            rd_bank_q  <= rd_bank_d;
            wr_row_q   <= wr_row_d;
            col_q      <= col_d;
            full_q     <= full_d;
            overflow_q <= overflow_d;
        end
    end

endmodule
